// File: rtl/writeback_pkg.sv
// writeback_pkg: shared widths and entry layout for the writeback path and register file
package writeback_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
  function automatic int entry_w(input int aw, input int dw);
    return aw + dw;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular buffer of writeback entries with per-entry valid tracking
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 19,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push,
  input  logic                    pop,
  input  logic [W-1:0]            din,
  output logic [DEPTH-1:0][W-1:0] ent,
  output logic [DEPTH-1:0]        vld,
  output logic [PW-1:0]           rp,
  output logic [CW-1:0]           count,
  output logic                    full,
  output logic                    empty
);
  logic [PW-1:0] wp;
  // pointers, occupancy and valid bits; flush behaves like a synchronous clear
  always_ff @(posedge clk or posedge rst)
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      vld <= '0;
    end else begin
      if (push) begin
        wp <= wp + 1'b1;
        vld[wp] <= 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
        vld[rp] <= 1'b0;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  // entry storage is left unreset; vld gates every use of it
  always_ff @(posedge clk)
    if (push && !flush) ent[wp] <= din;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: arbitrates load/ALU results into a writeback queue with hazard forwarding
module writeback_unit
  import writeback_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DATA_W = writeback_pkg::DATA_W,
  parameter int ADDR_W = writeback_pkg::ADDR_W,
  localparam int W = entry_w(ADDR_W, DATA_W),
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              hold,
  input  logic              flush,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] q_addr1,
  input  logic [ADDR_W-1:0] q_addr2,
  output logic              pend1,
  output logic              pend2,
  output logic [DATA_W-1:0] fwd1,
  output logic [DATA_W-1:0] fwd2,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);
  logic [DEPTH-1:0][W-1:0] ent;
  logic [DEPTH-1:0] vld;
  logic [PW-1:0] rp;
  logic ld_fire, alu_fire, push;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  assign ld_ready = !full && !flush;
  assign alu_ready = !full && !flush && !ld_valid;
  assign ld_fire = ld_valid && ld_ready;
  assign alu_fire = alu_valid && alu_ready;
  assign sel_addr = ld_fire ? ld_addr : alu_addr;
  assign sel_data = ld_fire ? ld_data : alu_data;
  assign push = (ld_fire || alu_fire) && sel_addr != '0;
  assign we = !empty && !hold && !flush;
  assign waddr = we ? ent[rp][DATA_W +: ADDR_W] : '0;
  assign wdata = we ? ent[rp][DATA_W-1:0] : '0;
  wb_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .pop(we),
    .din({sel_addr, sel_data}), .ent(ent), .vld(vld), .rp(rp),
    .count(count), .full(full), .empty(empty)
  );
  // scan oldest to youngest so the last match left standing is the youngest
  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    fwd1 = '0;
    fwd2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (vld[rp + PW'(k)] && q_addr1 != '0 && ent[rp + PW'(k)][DATA_W +: ADDR_W] == q_addr1) begin
        pend1 = 1'b1;
        fwd1 = ent[rp + PW'(k)][DATA_W-1:0];
      end
      if (vld[rp + PW'(k)] && q_addr2 != '0 && ent[rp + PW'(k)][DATA_W +: ADDR_W] == q_addr2) begin
        pend2 = 1'b1;
        fwd2 = ent[rp + PW'(k)][DATA_W-1:0];
      end
    end
  end
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: randomized and directed scoreboard bench for writeback_unit
module tb_writeback_unit;
  localparam int DEPTH = 4;
  typedef struct {
    logic [2:0]  a;
    logic [15:0] d;
  } ent_t;
  logic clk = 0, rst = 1;
  logic ld_valid = 0, alu_valid = 0, hold = 0, flush = 0;
  logic [2:0] ld_addr = 0, alu_addr = 0, q_addr1 = 0, q_addr2 = 0, waddr;
  logic [15:0] ld_data = 0, alu_data = 0, wdata, fwd1, fwd2;
  logic ld_ready, alu_ready, we, pend1, pend2, full, empty;
  logic [2:0] count;
  int tests = 0, fails = 0;
  ent_t exp_wr[$];
  bit pend_push = 0, pend_flush = 0;
  ent_t pend_e;

  writeback_unit #(.DEPTH(DEPTH), .DATA_W(16), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_data(ld_data), .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr),
    .alu_data(alu_data), .hold(hold), .flush(flush), .we(we), .waddr(waddr), .wdata(wdata),
    .q_addr1(q_addr1), .q_addr2(q_addr2), .pend1(pend1), .pend2(pend2), .fwd1(fwd1),
    .fwd2(fwd2), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference lookup: youngest queued write to address q
  task automatic lookup(input logic [2:0] q, output logic p, output logic [15:0] f);
    p = 0;
    f = 0;
    foreach (exp_wr[i])
      if (q != 0 && exp_wr[i].a == q) begin
        p = 1;
        f = exp_wr[i].d;
      end
  endtask

  // monitor: compares every output mid-cycle and retires expected writes in order
  always @(negedge clk) begin
    logic ew, ep1, ep2;
    logic [15:0] ef1, ef2;
    int n;
    n = exp_wr.size();
    ew = n > 0 && !hold && !flush;
    chk("count", count, n);
    chk("empty", empty, n == 0);
    chk("full", full, n == DEPTH);
    chk("ld_ready", ld_ready, n < DEPTH && !flush);
    chk("alu_ready", alu_ready, n < DEPTH && !flush && !ld_valid);
    chk("we", we, ew);
    lookup(q_addr1, ep1, ef1);
    lookup(q_addr2, ep2, ef2);
    chk("pend1", pend1, ep1);
    chk("pend2", pend2, ep2);
    chk("fwd1", fwd1, ef1);
    chk("fwd2", fwd2, ef2);
    if (ew) begin
      chk("waddr", waddr, exp_wr[0].a);
      chk("wdata", wdata, exp_wr[0].d);
      void'(exp_wr.pop_front());
    end else begin
      chk("waddr_idle", waddr, 0);
      chk("wdata_idle", wdata, 0);
    end
  end

  task automatic apply();
    if (pend_flush) exp_wr.delete();
    else if (pend_push) exp_wr.push_back(pend_e);
    pend_push = 0;
    pend_flush = 0;
  endtask

  // one cycle of stimulus; q < 0 picks a random query address
  task automatic drive(input bit lv, input logic [2:0] la, input logic [15:0] ldd,
                       input bit av, input logic [2:0] aa, input logic [15:0] ad,
                       input bit h, input bit f, input int q1, input int q2);
    bit lr, ar;
    @(posedge clk);
    apply();
    #1;
    ld_valid = lv; ld_addr = la; ld_data = ldd;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    hold = h; flush = f;
    q_addr1 = q1 < 0 ? 3'($urandom_range(0, 7)) : 3'(q1);
    q_addr2 = q2 < 0 ? 3'($urandom_range(0, 7)) : 3'(q2);
    lr = exp_wr.size() < DEPTH && !f;
    ar = lr && !lv;
    pend_flush = f;
    if (lv && lr) begin
      pend_push = la != 0;
      pend_e = '{la, ldd};
    end else if (av && ar) begin
      pend_push = aa != 0;
      pend_e = '{aa, ad};
    end
  endtask

  task automatic idle(input int n, input bit h);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, h, 0, -1, -1);
  endtask

  // reset asserted between edges; outputs must clear before the next edge
  task automatic rst_mid();
    @(posedge clk);
    apply();
    #3;
    rst = 1;
    ld_valid = 0; alu_valid = 0; flush = 0; hold = 0;
    exp_wr.delete();
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_we", we, 0);
    chk("rst_count", count, 0);
    chk("rst_pend1", pend1, 0);
    @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    drive(1, 3, 16'h1234, 0, 0, 0, 0, 0, 3, 0);
    idle(2, 0);
    drive(1, 2, 16'h00a2, 1, 4, 16'h00b4, 0, 0, 4, 2);
    drive(0, 0, 0, 1, 4, 16'h00b4, 0, 0, 4, 2);
    idle(3, 0);
    for (int i = 1; i <= 5; i++) drive(1, 3'(i), 16'(i * 16'h111), 0, 0, 0, 1, 0, i, 1);
    idle(6, 0);
    drive(1, 5, 16'h0001, 0, 0, 0, 1, 0, 5, 0);
    drive(0, 0, 0, 1, 5, 16'h0002, 1, 0, 5, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 5, 0);
    idle(3, 0);
    drive(1, 0, 16'hffff, 0, 0, 0, 0, 0, 0, 0);
    idle(2, 0);
    drive(1, 6, 16'h0606, 0, 0, 0, 1, 0, 6, 7);
    drive(1, 7, 16'h0707, 0, 0, 0, 1, 0, 6, 7);
    drive(1, 1, 16'h0101, 0, 0, 0, 0, 1, 6, 7);
    idle(3, 0);
    for (int i = 1; i <= 3; i++) drive(0, 0, 0, 1, 3'(i), 16'(i), 1, 0, -1, -1);
    rst_mid();
    idle(3, 0);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) rst_mid();
      else drive($urandom_range(0, 99) < 45, 3'($urandom), 16'($urandom),
                 $urandom_range(0, 99) < 55, 3'($urandom), 16'($urandom),
                 $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 4, -1, -1);
    end
    idle(DEPTH + 3, 0);
    chk("drained", exp_wr.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of queue entries (power of two, at least 2).
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning the register data width.
REQ-003 The block SHALL have parameter ADDR_W, default 3, meaning the register address width.
REQ-004 The block SHALL have these ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ld_valid / ld_ready  in / out  1 / 1  load-result handshake.
- ld_addr / ld_data  in / in  ADDR_W / DATA_W  load destination and value.
- alu_valid / alu_ready  in / out  1 / 1  ALU-result handshake.
- alu_addr / alu_data  in / in  ADDR_W / DATA_W  ALU destination and value.
- hold  in  1  stall draining into the register file.
- flush  in  1  discard all queued entries.
- we / waddr / wdata  out / out / out  1 / ADDR_W / DATA_W  register-file write port.
- q_addr1, q_addr2  in  ADDR_W each  hazard query addresses.
- pend1, pend2  out  1 each  a queued write targets q_addrN.
- fwd1, fwd2  out  DATA_W each  data of the youngest queued write to q_addrN; 0 if none.
- count  out  clog2(DEPTH+1)  occupancy.
- full, empty  out  1 each  count==DEPTH / count==0.

Function
REQ-005 A transfer on a source SHALL occur on a rising edge where its valid and ready are both high.
REQ-006 ld_ready SHALL equal !full && !flush; alu_ready SHALL equal !full && !flush && !ld_valid (fixed priority: load wins).
REQ-007 At most one entry SHALL be enqueued per cycle, at the tail.
REQ-008 A transfer with address 0 SHALL complete the handshake but SHALL NOT be enqueued (r0 is hardwired zero).
REQ-009 we SHALL be combinationally !empty && !hold && !flush; waddr/wdata SHALL be the head entry, and 0 when we is low.
REQ-010 The head SHALL be popped on every edge where we is high; latency from accept to write edge is 1 cycle minimum, in FIFO order.
REQ-011 Simultaneous enqueue and pop SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-012 When full, no source is ready; the head still pops if hold is low, and ready returns the cycle after.
REQ-013 When empty, no pop occurs and we stays low regardless of hold.
REQ-014 flush high at an edge SHALL clear count and both pointers, accept nothing and perform no write that cycle.
REQ-015 pendN SHALL be high iff q_addrN != 0 and some valid entry has that address; purely combinational over queue contents.
REQ-016 fwdN SHALL be the data of the youngest (closest to tail) matching valid entry.
REQ-017 An entry being written this cycle (we high) SHALL still count toward pendN/fwdN.

Reset
REQ-018 rst high SHALL immediately clear pointers and count; empty=1, full=0, we=0, waddr=0, wdata=0, pend1/2=0, fwd1/2=0, count=0.
REQ-019 Reset mid-operation SHALL discard all queued entries without any register-file write.
REQ-020 Entry storage need not be reset; valid tracking alone SHALL gate all outputs.

Structure
REQ-021 DATA_W, ADDR_W and the entry layout {addr, data} SHALL live in a shared package/include, writeback_pkg, used by this block and the register file.
REQ-022 The circular buffer (storage, pointers, count, per-entry valid) SHALL be a sub-module wb_fifo; arbitration, r0 filtering and the hazard/forward search stay in writeback_unit.

Verification
REQ-023 Basic: reset, ld r3=0x1234 accepted at edge N -> we=1, waddr=3, wdata=0x1234 in cycle N+1; empty=1 after edge N+1.
REQ-024 Priority: ld_valid and alu_valid both high -> alu_ready=0; ld entry queued first, ALU entry accepted the next cycle.
REQ-025 Full/hold: hold=1, enqueue r1..r4 -> full=1, both ready=0, count=4; drop hold -> writes r1,r2,r3,r4 on 4 consecutive cycles.
REQ-026 Forwarding: queue r5=0x0001 then r5=0x0002 with hold=1, q_addr1=5 -> pend1=1, fwd1=0x0002; q_addr2=0 -> pend2=0, fwd2=0.
REQ-027 r0 and flush: enqueue r0=0xFFFF -> count stays 0, no write; queue 2 entries, pulse flush -> count=0, no we that cycle or after.
REQ-028 Async reset: assert rst mid-cycle with 3 entries queued -> empty=1, we=0 before the next edge; no writes after release.
